// File: rtl/sram_arb_if.sv
// sram_arb_if: bundles the two requester ports, the SRAM controller side and
// the status outputs of the sram_arb block.
//   p0_* / p1_* : requester ports (req/we/be/addr/wdata in, rdata/ack/err out)
//   sram_*      : controller start, command, address, write data, read data, ready
//   busy, timeout_sticky : arbiter status
// Modport slave is taken by the arbiter; modport master is the environment
// (requesters plus controller).
interface sram_arb_if;
   logic        p0_req;
   logic        p0_we;
   logic        p0_be;
   logic [20:0] p0_addr;
   logic [31:0] p0_wdata;
   logic [31:0] p0_rdata;
   logic        p0_ack;
   logic        p0_err;

   logic        p1_req;
   logic        p1_we;
   logic        p1_be;
   logic [20:0] p1_addr;
   logic [31:0] p1_wdata;
   logic [31:0] p1_rdata;
   logic        p1_ack;
   logic        p1_err;

   logic        sram_en;
   logic        sram_we;
   logic        sram_be;
   logic [20:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_rdy;

   logic        busy;
   logic        timeout_sticky;

   modport slave (
      input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
      output p0_rdata, p0_ack, p0_err,
      input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
      output p1_rdata, p1_ack, p1_err,
      output sram_en, sram_we, sram_be, sram_addr, sram_wdata,
      input  sram_rdata, sram_rdy,
      output busy, timeout_sticky
   );

   modport master (
      output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
      input  p0_rdata, p0_ack, p0_err,
      output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
      input  p1_rdata, p1_ack, p1_err,
      input  sram_en, sram_we, sram_be, sram_addr, sram_wdata,
      output sram_rdata, sram_rdy,
      input  busy, timeout_sticky
   );
endinterface

// File: rtl/sram_arb.sv
// sram_arb: two-port arbiter / sequencer in front of the DE2-115 SRAM
// controller. One transaction at a time: pick a winner, give the controller a
// single start pulse, hold the command stable until the controller reports
// ready (or the watchdog fires), then return read data and a one-cycle ack.
// Ports:
//   clk  - controller clock
//   rst  - asynchronous active-high reset (shared with the controller)
//   bus  - sram_arb_if.slave: requester ports p0/p1, controller sram_*,
//          busy and timeout_sticky status
// Parameters:
//   PRIO    - 0: round-robin on ties, 1: port 0 always wins
//   TIMEOUT - WAIT cycles allowed before the transaction is aborted (>= 5)
module sram_arb #(
   parameter int PRIO    = 0,
   parameter int TIMEOUT = 16
) (
   input logic      clk,
   input logic      rst,
   sram_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   localparam int             CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   state_t        state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_q, en_d;
   logic          we_q, we_d;
   logic          be_q, be_d;
   logic [20:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata0_q, rdata0_d;
   logic [31:0]   rdata1_q, rdata1_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          err0_q, err0_d;
   logic          err1_q, err1_d;
   logic          busy_q, busy_d;
   logic          sticky_q, sticky_d;
   logic          grant;

   // Winner when at least one port requests (1 = port 1).
   always_comb begin
      grant = 1'b0;
      if (PRIO != 0)
         grant = ~bus.p0_req;
      else if (bus.p0_req && bus.p1_req)
         grant = ~last_q;
      else
         grant = ~bus.p0_req;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      en_d     = 1'b0;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      sticky_d = sticky_q;
      unique case (state_q)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               sel_d   = grant;
               last_d  = grant;
               we_d    = grant ? bus.p1_we    : bus.p0_we;
               be_d    = grant ? bus.p1_be    : bus.p0_be;
               addr_d  = grant ? bus.p1_addr  : bus.p0_addr;
               wdata_d = grant ? bus.p1_wdata : bus.p0_wdata;
               en_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Command registers are left untouched here: the controller
            // samples address/data live during its first phase.
            cnt_d = cnt_q + CNT_ONE;
            if (bus.sram_rdy) begin
               if (!we_q) begin
                  if (sel_q) rdata1_d = bus.sram_rdata;
                  else       rdata0_d = bus.sram_rdata;
               end
               ack0_d  = ~sel_q;
               ack1_d  = sel_q;
               state_d = ACK;
            end else if (cnt_q == CNT_MAX) begin
               ack0_d   = ~sel_q;
               ack1_d   = sel_q;
               err0_d   = ~sel_q;
               err1_d   = sel_q;
               sticky_d = 1'b1;
               state_d  = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;   // port 0 wins the first tie
         cnt_q    <= '0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         busy_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         busy_q   <= busy_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.sram_en        = en_q;
   assign bus.sram_we        = we_q;
   assign bus.sram_be        = be_q;
   assign bus.sram_addr      = addr_q;
   assign bus.sram_wdata     = wdata_q;
   assign bus.p0_rdata       = rdata0_q;
   assign bus.p1_rdata       = rdata1_q;
   assign bus.p0_ack         = ack0_q;
   assign bus.p1_ack         = ack1_q;
   assign bus.p0_err         = err0_q;
   assign bus.p1_err         = err1_q;
   assign bus.busy           = busy_q;
   assign bus.timeout_sticky = sticky_q;
endmodule
